// File: rtl/tqvp_apu_pkg.sv
// Shared definitions for the TinyQV APU channel blocks.
//   - Register map addresses of the pulse channel.
//   - ctrl_t: field layout of the CTRL register.
//   - DUTY_TABLE: 8-step duty patterns; bit (7 - step) is the output level.
//   - LEN_TABLE: length counter load values selected by the 5-bit index in THI.
//   - duty_level(): looks up the duty level for a duty setting and sequencer step.
package tqvp_apu_pkg;

    localparam logic [3:0] ADDR_CTRL = 4'd0;
    localparam logic [3:0] ADDR_TLO  = 4'd1;
    localparam logic [3:0] ADDR_THI  = 4'd2;
    localparam logic [3:0] ADDR_EN   = 4'd3;
    localparam logic [3:0] ADDR_STAT = 4'd4;

    typedef struct packed {
        logic [1:0] duty;
        logic       halt;       // halts the length counter and loops the envelope
        logic       const_vol;
        logic [3:0] vol;        // constant volume, or the envelope divider period
    } ctrl_t;

    localparam logic [7:0] DUTY_TABLE [4] = '{
        8'b01000000, 8'b01100000, 8'b01111000, 8'b10011111
    };

    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    function automatic logic duty_level(input logic [1:0] duty, input logic [2:0] step);
        logic [7:0] pattern;
        pattern = DUTY_TABLE[duty];
        return pattern[3'd7 - step];
    endfunction

endpackage

// File: rtl/tqvp_apu_envelope.sv
// Envelope generator shared by the pulse and noise channels.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   qframe      one-cycle quarter-frame clock enable
//   restart     one-cycle request to restart the envelope (sets the start flag)
//   loop        when decay reaches 0, wrap back to 15 instead of holding
//   period[3:0] divider reload value
//   decay[3:0]  current envelope level
// A restart never acts immediately: it only sets the start flag, and the
// reload to 15 happens on the following quarter-frame. A restart arriving
// in the same cycle as a quarter-frame therefore takes effect one
// quarter-frame later.
module tqvp_apu_envelope (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       qframe,
    input  logic       restart,
    input  logic       loop,
    input  logic [3:0] period,
    output logic [3:0] decay
);

    logic       start_q, start_d;
    logic [3:0] decay_q, decay_d;
    logic [3:0] div_q, div_d;

    always_comb begin
        start_d = start_q;
        decay_d = decay_q;
        div_d   = div_q;

        if (qframe) begin
            if (start_q) begin
                start_d = 1'b0;
                decay_d = 4'd15;
                div_d   = period;
            end else if (div_q == 4'd0) begin
                div_d = period;
                if (decay_q != 4'd0) begin
                    decay_d = decay_q - 4'd1;
                end else if (loop) begin
                    decay_d = 4'd15;
                end
            end else begin
                div_d = div_q - 4'd1;
            end
        end

        // Set after the quarter-frame handling so a coincident restart survives.
        if (restart) begin
            start_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            decay_q <= 4'd0;
            div_q   <= 4'd0;
        end else begin
            start_q <= start_d;
            decay_q <= decay_d;
            div_q   <= div_d;
        end
    end

    assign decay = decay_q;

endmodule

// File: rtl/tqvp_apu_pulse.sv
// TinyQV byte peripheral: one 2A03-style pulse (square) channel.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   ui_in[7:0]   input PMOD (not used by this channel)
//   uo_out[7:0]  [3:0] sample for the R-2R DAC, [4] raw duty level, [7:5] zero
//   address[3:0] register select
//   data_write   one-cycle write strobe, data_in valid with it
//   data_in[7:0] write data
//   data_out[7:0] read data, combinational from address
// Register map: 0 CTRL, 1 TLO, 2 THI, 3 EN, 4 STAT (read-only:
// {3'b0, sample, length!=0}); other addresses read 0 and ignore writes.
// An internal prescaler produces apu_tick every CLK_DIV clocks; a frame
// counter divides apu_ticks by QF_DIV into quarter-frames, every second one
// also being a half-frame.
module tqvp_apu_pulse
    import tqvp_apu_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int QF_DIV  = 3729
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int QW = (QF_DIV > 1) ? $clog2(QF_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [QW-1:0] QF_LAST    = QW'(QF_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [QW-1:0] qf_q, qf_d;
    logic          hf_q, hf_d;
    logic          apu_tick, qframe, hframe;

    ctrl_t       ctrl_q, ctrl_d;
    logic [7:0]  tlo_q, tlo_d;
    logic [7:0]  thi_q, thi_d;
    logic        en_q, en_d;

    logic [10:0] timer_q, timer_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  uo_q, uo_d;

    logic        wr_ctrl, wr_tlo, wr_thi, wr_en;
    logic [10:0] period;
    logic        level;
    logic        len_nz;
    logic [3:0]  decay;
    logic [3:0]  vol_out;
    logic [3:0]  sample;

    // The input PMOD has no function in this channel.
    logic unused_ui;
    assign unused_ui = ^ui_in;

    assign wr_ctrl = data_write && (address == ADDR_CTRL);
    assign wr_tlo  = data_write && (address == ADDR_TLO);
    assign wr_thi  = data_write && (address == ADDR_THI);
    assign wr_en   = data_write && (address == ADDR_EN);

    assign period = {thi_q[2:0], tlo_q};
    assign len_nz = (len_q != 8'd0);

    // Frame pacing
    assign apu_tick = (presc_q == PRESC_LAST);
    assign qframe   = apu_tick && (qf_q == QF_LAST);
    assign hframe   = qframe && hf_q;

    always_comb begin
        presc_d = apu_tick ? '0 : presc_q + 1'b1;
        qf_d    = qf_q;
        hf_d    = hf_q;
        if (apu_tick) begin
            qf_d = qframe ? '0 : qf_q + 1'b1;
            if (qframe) begin
                hf_d = ~hf_q;
            end
        end
    end

    // Register file
    always_comb begin
        ctrl_d = ctrl_q;
        tlo_d  = tlo_q;
        thi_d  = thi_q;
        en_d   = en_q;
        if (wr_ctrl) ctrl_d = ctrl_t'(data_in);
        if (wr_tlo)  tlo_d  = data_in;
        if (wr_thi)  thi_d  = data_in;
        if (wr_en)   en_d   = data_in[0];
    end

    // Timer and duty sequencer. A THI write restarts the sequence at step 0
    // but leaves the timer running, so the first step after it may be short.
    always_comb begin
        timer_d = timer_q;
        step_d  = step_q;
        if (apu_tick) begin
            if (timer_q == 11'd0) begin
                timer_d = period;
                step_d  = step_q + 3'd1;
            end else begin
                timer_d = timer_q - 11'd1;
            end
        end
        if (wr_thi) begin
            step_d = 3'd0;
        end
    end

    // Length counter. Later assignments take priority: a load beats a
    // coincident half-frame decrement, and disabling clears immediately.
    always_comb begin
        len_d = len_q;
        if (hframe && len_nz && !ctrl_q.halt) begin
            len_d = len_q - 8'd1;
        end
        if (wr_thi && en_q) begin
            len_d = LEN_TABLE[data_in[7:3]];
        end
        if (wr_en && !data_in[0]) begin
            len_d = 8'd0;
        end
    end

    tqvp_apu_envelope u_envelope (
        .clk     (clk),
        .rst_n   (rst_n),
        .qframe  (qframe),
        .restart (wr_thi),
        .loop    (ctrl_q.halt),
        .period  (ctrl_q.vol),
        .decay   (decay)
    );

    // Output mixing; periods below 8 are silenced without stopping the sequencer.
    always_comb begin
        level   = duty_level(ctrl_q.duty, step_q);
        vol_out = ctrl_q.const_vol ? ctrl_q.vol : decay;
        sample  = (level && len_nz && (period >= 11'd8) && en_q) ? vol_out : 4'd0;
        uo_d    = {3'b000, level, sample};
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_CTRL: data_out = ctrl_q;
            ADDR_TLO:  data_out = tlo_q;
            ADDR_THI:  data_out = thi_q;
            ADDR_EN:   data_out = {7'b0000000, en_q};
            ADDR_STAT: data_out = {3'b000, uo_q[3:0], len_nz};
            default:   data_out = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            qf_q    <= '0;
            hf_q    <= 1'b0;
            ctrl_q  <= '0;
            tlo_q   <= 8'd0;
            thi_q   <= 8'd0;
            en_q    <= 1'b0;
            timer_q <= 11'd0;
            step_q  <= 3'd0;
            len_q   <= 8'd0;
            uo_q    <= 8'd0;
        end else begin
            presc_q <= presc_d;
            qf_q    <= qf_d;
            hf_q    <= hf_d;
            ctrl_q  <= ctrl_d;
            tlo_q   <= tlo_d;
            thi_q   <= thi_d;
            en_q    <= en_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            len_q   <= len_d;
            uo_q    <= uo_d;
        end
    end

    assign uo_out = uo_q;

endmodule
